// File: rtl/cipher_arb_pkg.sv
// Shared types, constants and grant helpers for the cipher arbiter.
package cipher_arb_pkg;

  localparam int unsigned NUM_PORTS      = 2;
  // 32 rounds plus the cipher's input and output registers.
  localparam int unsigned CIPHER_LATENCY = 34;
  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned DEFAULT_DEPTH  = 64;

  // One bit is enough to name either requester.
  typedef logic port_id_t;

  // Round-robin pick: a lone requester wins; on contention the port that did
  // not issue last wins.
  function automatic port_id_t rr_pick(logic [NUM_PORTS-1:0] req, port_id_t last);
    port_id_t pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last;
    endcase
    return pick;
  endfunction

  // Fixed priority pick: port 0 wins whenever it is requesting.
  function automatic port_id_t fixed_pick(logic [NUM_PORTS-1:0] req);
    port_id_t pick;
    if (req[0]) begin
      pick = 1'b0;
    end else if (req[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cipher_arbiter_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tready) used for every arbiter port.
interface cipher_arbiter_if #(
  parameter int unsigned DATA_W = 64
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  // Drives tdata/tvalid, receives tready.
  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  // Receives tdata/tvalid, drives tready.
  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/tag_fifo.sv
// In-order FIFO of requester IDs, one entry per block in flight in the cipher.
// Pointers wrap naturally; occupancy lives in its own counter so full and empty
// never need a spare pointer bit. DEPTH must be a power of two.
module tag_fifo
  import cipher_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  port_id_t                     push_id,
  input  logic                         pop,
  output port_id_t                     head_id,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  port_id_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Status flags, guarded push/pop and next pointer/occupancy values.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    // Push and pop together leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign head_id = mem_q[rptr_q];
  assign count   = count_q;

  // Pointer and occupancy registers; reset discards every in-flight tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_id;
    end
  end

  // The arbiter only pushes with credit and only pops a non-empty FIFO.
  assert property (@(posedge clk) disable iff (!rst) !(push && full));
  assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/cipher_arbiter.sv
// Shares one in-order pipelined cipher between two AXI-Stream requesters.
// Issue side: round-robin grant with a lock that pins a stalled beat to its
// source until the cipher accepts it. Each issued block's source ID goes into
// tag_fifo; the head tag steers the returning ciphertext back to its issuer.
// Define CIPHER_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins on
// contention, no round-robin pointer); lock behaviour is the same either way.
module cipher_arbiter
  import cipher_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  cipher_arbiter_if.slave            s0_axis,
  cipher_arbiter_if.slave            s1_axis,
  cipher_arbiter_if.master           enc_m_axis,
  cipher_arbiter_if.slave            enc_s_axis,
  cipher_arbiter_if.master           m0_axis,
  cipher_arbiter_if.master           m1_axis,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_orphan
);

  logic [NUM_PORTS-1:0] req;
  port_id_t             pick;
  port_id_t             grant;
  logic                 can_issue;
  logic                 issue_valid;
  logic                 issue_hs;
  logic [DATA_W-1:0]    issue_data;

  logic                 lock_q, lock_d;
  port_id_t             lock_id_q, lock_id_d;

  port_id_t             head_id;
  logic                 tag_full, tag_empty;
  logic                 ret_valid;
  logic                 pop;
  logic                 err_orphan_q, err_orphan_d;

`ifdef CIPHER_ARB_FIXED_PRIO_EN
  // Fixed priority needs no history.
  always_comb begin
    pick = fixed_pick(req);
  end
`else
  port_id_t rr_q, rr_d;

  // Contended grants alternate away from the last issuer.
  always_comb begin
    pick = rr_pick(req, rr_q);
    rr_d = rr_q;
    if (issue_hs) begin
      rr_d = grant;
    end
  end

  // Round-robin pointer starts at 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Credit is the registered occupancy, so a pop never frees issue in the same cycle.
  assign can_issue = !tag_full;

  // Grant selection and issue-side handshake routing.
  always_comb begin
    req                = {s1_axis.tvalid, s0_axis.tvalid};
    grant              = lock_q ? lock_id_q : pick;
    issue_valid        = can_issue && (grant ? s1_axis.tvalid : s0_axis.tvalid);
    issue_data         = grant ? s1_axis.tdata : s0_axis.tdata;
    enc_m_axis.tvalid  = issue_valid;
    enc_m_axis.tdata   = issue_data;
    s0_axis.tready     = can_issue && (grant == 1'b0) && enc_m_axis.tready;
    s1_axis.tready     = can_issue && (grant == 1'b1) && enc_m_axis.tready;
    issue_hs           = issue_valid && enc_m_axis.tready;
  end

  // A presented but unaccepted beat pins the grant so its data stays stable.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (issue_hs) begin
      lock_d = 1'b0;
    end else if (issue_valid) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  tag_fifo #(
    .DEPTH   (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (issue_hs),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (outstanding)
  );

  // Return routing: only the head tag's requester sees the beat, and its
  // tready alone gates the cipher (in-order head-of-line blocking).
  always_comb begin
    ret_valid         = enc_s_axis.tvalid && !tag_empty;
    m0_axis.tvalid    = ret_valid && (head_id == 1'b0);
    m1_axis.tvalid    = ret_valid && (head_id == 1'b1);
    m0_axis.tdata     = enc_s_axis.tdata;
    m1_axis.tdata     = enc_s_axis.tdata;
    enc_s_axis.tready = !tag_empty && (head_id ? m1_axis.tready : m0_axis.tready);
    pop               = enc_s_axis.tvalid && enc_s_axis.tready;
    err_orphan_d      = err_orphan_q || (enc_s_axis.tvalid && tag_empty);
  end

  // Sticky orphan flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_orphan_q <= 1'b0;
    end else begin
      err_orphan_q <= err_orphan_d;
    end
  end

  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_cipher_arbiter.sv
// Bench for cipher_arbiter (DEPTH=4). The bench plays the cipher itself
// (returns tdata ^ KEY in order) and keeps per-requester queues of expected
// ciphertext, filled when stimulus is issued and drained as mN beats appear.
module tb_cipher_arbiter;
  import cipher_arb_pkg::*;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] KEY   = 64'hA5A5_0F0F_3C3C_9696;
  localparam logic [63:0] ORPH  = 64'hDEAD_BEEF_0000_0001;
  localparam int          BIG   = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cipher_arbiter_if #(.DATA_W(DW)) s0_if ();
  cipher_arbiter_if #(.DATA_W(DW)) s1_if ();
  cipher_arbiter_if #(.DATA_W(DW)) enc_m_if ();
  cipher_arbiter_if #(.DATA_W(DW)) enc_s_if ();
  cipher_arbiter_if #(.DATA_W(DW)) m0_if ();
  cipher_arbiter_if #(.DATA_W(DW)) m1_if ();

  logic [2:0] outstanding;
  logic       err_orphan;

  cipher_arbiter #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s0_axis     (s0_if),
    .s1_axis     (s1_if),
    .enc_m_axis  (enc_m_if),
    .enc_s_axis  (enc_s_if),
    .m0_axis     (m0_if),
    .m1_axis     (m1_if),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  // Stimulus state applied on the next cycle.
  logic        s0_v = 0, s1_v = 0, enc_rdy = 0, m0_r = 0, m1_r = 0, orphan_inj = 0;
  logic [63:0] s0_d = '0, s1_d = '0;
  int          ret_limit = BIG;
  int          ret_done = 0;
  logic        iss_hs = 0, ret_hs = 0;
  logic [63:0] iss_data = '0;
  logic [63:0] cq[$];
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  int          n_pass = 0, n_chk = 0, cycles = 0;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        exp_v;
    logic        exp_p;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp_v);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp_v);
  endtask

  task automatic push_exp(input logic p, input logic [63:0] d);
    if (p) exp1.push_back(d ^ KEY);
    else exp0.push_back(d ^ KEY);
  endtask

  // One clock: update the cipher model, apply inputs after the edge, then
  // sample and score requester outputs at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (ret_hs) begin
      cq.delete(0);
      ret_done++;
    end
    if (iss_hs) cq.push_back(iss_data);
    s0_if.tvalid    = s0_v;
    s0_if.tdata     = s0_d;
    s1_if.tvalid    = s1_v;
    s1_if.tdata     = s1_d;
    enc_m_if.tready = enc_rdy;
    m0_if.tready    = m0_r;
    m1_if.tready    = m1_r;
    enc_s_if.tvalid = orphan_inj || (cq.size() != 0 && ret_done < ret_limit);
    enc_s_if.tdata  = (cq.size() != 0) ? (cq[0] ^ KEY) : ORPH;
    @(negedge clk);
    iss_hs   = enc_m_if.tvalid && enc_m_if.tready;
    iss_data = enc_m_if.tdata;
    ret_hs   = enc_s_if.tvalid && enc_s_if.tready;
    if (m0_if.tvalid && m0_if.tready) begin
      chk1("m0 beat exclusive", m1_if.tvalid, 1'b0);
      if (exp0.size() == 0) begin
        n_chk++;
        $display("FAIL m0 unexpected beat: got 0x%h, expected none", m0_if.tdata);
      end else chk("m0 data", m0_if.tdata, exp0.pop_front());
    end
    if (m1_if.tvalid && m1_if.tready) begin
      chk1("m1 beat exclusive", m0_if.tvalid, 1'b0);
      if (exp1.size() == 0) begin
        n_chk++;
        $display("FAIL m1 unexpected beat: got 0x%h, expected none", m1_if.tdata);
      end else chk("m1 data", m1_if.tdata, exp1.pop_front());
    end
    cycles++;
    if (cycles > 4000) begin
      n_chk++;
      $display("FAIL timeout: ran %0d cycles, expected under 4000", cycles);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // Present one beat on port p and hold it until accepted (bounded).
  task automatic send1(input logic p, input logic [63:0] d);
    logic done = 1'b0;
    if (p) begin s1_v = 1'b1; s1_d = d; end
    else begin s0_v = 1'b1; s0_d = d; end
    enc_rdy = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      if (p ? (s1_if.tvalid && s1_if.tready) : (s0_if.tvalid && s0_if.tready)) done = 1'b1;
    end
    chk1("send1 accepted", done, 1'b1);
    if (done) push_exp(p, d);
    s0_v = 1'b0;
    s1_v = 1'b0;
  endtask

  // Let every in-flight block return, then confirm nothing is left over.
  task automatic drain();
    s0_v = 0; s1_v = 0; m0_r = 1; m1_r = 1; enc_rdy = 1; ret_limit = BIG;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (outstanding == 0 && cq.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && !iss_hs)
        break;
    end
    chk("drain outstanding", 64'(outstanding), 64'd0);
    chk("drain exp0 left", 64'(exp0.size()), 64'd0);
    chk("drain exp1 left", 64'(exp1.size()), 64'd0);
  endtask

  initial begin
    logic        p_next;
    logic        exp_p;
    logic [63:0] d;
    int          n0, n1;

    // Grant table, starting with the round-robin pointer at 0.
    vecs[0] = '{1, 1, 64'h1000_0000_0000_0000, 64'h1100_0000_0000_0000, 1, 1};
    vecs[1] = '{1, 1, 64'h1000_0000_0000_0001, 64'h1100_0000_0000_0001, 1, 0};
    vecs[2] = '{1, 0, 64'h1000_0000_0000_0002, 64'h1100_0000_0000_0002, 1, 0};
    vecs[3] = '{1, 1, 64'h1000_0000_0000_0003, 64'h1100_0000_0000_0003, 1, 1};
    vecs[4] = '{0, 1, 64'h1000_0000_0000_0004, 64'h1100_0000_0000_0004, 1, 1};
    vecs[5] = '{1, 1, 64'h1000_0000_0000_0005, 64'h1100_0000_0000_0005, 1, 0};
    vecs[6] = '{0, 0, 64'h1000_0000_0000_0006, 64'h1100_0000_0000_0006, 0, 0};
    vecs[7] = '{0, 1, 64'h1000_0000_0000_0007, 64'h1100_0000_0000_0007, 1, 1};
    vecs[8] = '{1, 1, 64'h1000_0000_0000_0008, 64'h1100_0000_0000_0008, 1, 0};

    // Reset state.
    cyc();
    cyc();
    chk("reset outstanding", 64'(outstanding), 64'd0);
    chk1("reset err_orphan", err_orphan, 1'b0);
    chk1("reset enc_m tvalid", enc_m_if.tvalid, 1'b0);
    chk1("reset enc_s tready", enc_s_if.tready, 1'b0);
    chk1("reset m0 tvalid", m0_if.tvalid, 1'b0);
    chk1("reset m1 tvalid", m1_if.tvalid, 1'b0);
    chk1("reset s0 tready", s0_if.tready, 1'b0);
    chk1("reset s1 tready", s1_if.tready, 1'b0);
    rst = 1'b1;
    cyc();

    // Single block from port 0 out and back.
    enc_rdy = 1; m0_r = 1; m1_r = 1;
    s0_v = 1; s0_d = 64'h0123_4567_89AB_CDEF;
    cyc();
    chk1("single enc_m tvalid", enc_m_if.tvalid, 1'b1);
    chk("single enc_m tdata", enc_m_if.tdata, 64'h0123_4567_89AB_CDEF);
    chk1("single s0 tready", s0_if.tready, 1'b1);
    push_exp(1'b0, 64'h0123_4567_89AB_CDEF);
    s0_v = 0;
    cyc();
    chk("single outstanding", 64'(outstanding), 64'd1);
    chk1("single m0 tvalid", m0_if.tvalid, 1'b1);
    chk1("single m1 tvalid", m1_if.tvalid, 1'b0);
    cyc();
    chk("single outstanding after", 64'(outstanding), 64'd0);
    chk("single exp0 left", 64'(exp0.size()), 64'd0);

    // Table-driven grant vectors.
    foreach (vecs[i]) begin
      s0_v = vecs[i].v0; s0_d = vecs[i].d0;
      s1_v = vecs[i].v1; s1_d = vecs[i].d1;
      cyc();
      chk1("vec enc_m tvalid", enc_m_if.tvalid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        d = vecs[i].exp_p ? vecs[i].d1 : vecs[i].d0;
        chk("vec enc_m tdata", enc_m_if.tdata, d);
        chk1("vec granted tready", vecs[i].exp_p ? s1_if.tready : s0_if.tready, 1'b1);
        chk1("vec other tready", vecs[i].exp_p ? s0_if.tready : s1_if.tready, 1'b0);
        push_exp(vecs[i].exp_p, d);
      end
    end
    drain();

    // Both ports stream 8 beats; issue must alternate 1,0,1,0,...
    n0 = 0; n1 = 0; p_next = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s0_v = (n0 < 8); s0_d = 64'h2000_0000_0000_0000 + 64'(n0);
      s1_v = (n1 < 8); s1_d = 64'h3000_0000_0000_0000 + 64'(n1);
      cyc();
      exp_p = p_next;
      d = exp_p ? s1_d : s0_d;
      chk1("burst enc_m tvalid", enc_m_if.tvalid, 1'b1);
      chk("burst enc_m tdata", enc_m_if.tdata, d);
      chk1("burst granted tready", exp_p ? s1_if.tready : s0_if.tready, 1'b1);
      push_exp(exp_p, d);
      if (exp_p) n1++;
      else n0++;
      p_next = ~p_next;
    end
    drain();

    // Lock: port 1 stalls, port 0 joins; grant must stay on port 1.
    send1(1'b1, 64'h4444_0000_0000_0001);
    enc_rdy = 0;
    s1_v = 1; s1_d = 64'hB0B0_B0B0_0000_0001;
    cyc();
    chk1("lock enc_m tvalid", enc_m_if.tvalid, 1'b1);
    chk("lock tdata first", enc_m_if.tdata, 64'hB0B0_B0B0_0000_0001);
    chk1("lock s1 tready stalled", s1_if.tready, 1'b0);
    s0_v = 1; s0_d = 64'h5A5A_5A5A_0000_0002;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk1("lock held tvalid", enc_m_if.tvalid, 1'b1);
      chk("lock held tdata", enc_m_if.tdata, 64'hB0B0_B0B0_0000_0001);
      chk1("lock s0 tready", s0_if.tready, 1'b0);
    end
    enc_rdy = 1;
    cyc();
    chk1("lock release s1 tready", s1_if.tready, 1'b1);
    chk1("lock release s0 tready", s0_if.tready, 1'b0);
    chk("lock release tdata", enc_m_if.tdata, 64'hB0B0_B0B0_0000_0001);
    push_exp(1'b1, 64'hB0B0_B0B0_0000_0001);
    s1_v = 0;
    cyc();
    chk1("lock next s0 tready", s0_if.tready, 1'b1);
    chk("lock next tdata", enc_m_if.tdata, 64'h5A5A_5A5A_0000_0002);
    push_exp(1'b0, 64'h5A5A_5A5A_0000_0002);
    s0_v = 0;
    drain();

    // Credit exhaustion with returns held, then one pop frees one slot.
    ret_limit = ret_done;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      s0_v = (n0 < 6); s0_d = 64'h6000_0000_0000_0000 + 64'(n0);
      cyc();
      if (k < 4) chk1("full issue open", enc_m_if.tvalid, 1'b1);
      if (k == 4) begin
        chk1("full issue blocked", enc_m_if.tvalid, 1'b0);
        chk("full outstanding", 64'(outstanding), 64'd4);
        ret_limit = ret_done + 1;
      end
      if (k == 5) begin
        chk1("full pop cycle still blocked", enc_m_if.tvalid, 1'b0);
        chk1("full pop cycle return", enc_s_if.tready, 1'b1);
      end
      if (k == 6) begin
        chk1("full credit restored", enc_m_if.tvalid, 1'b1);
        chk("full outstanding after pop", 64'(outstanding), 64'd3);
      end
      if (k == 7) begin
        chk1("full reblocked", enc_m_if.tvalid, 1'b0);
        chk("full outstanding again", 64'(outstanding), 64'd4);
      end
      if (s0_if.tvalid && s0_if.tready) begin
        push_exp(1'b0, s0_d);
        n0++;
      end
    end
    ret_limit = BIG;
    for (int k = 0; k < 20 && n0 < 6; k++) begin
      s0_v = 1; s0_d = 64'h6000_0000_0000_0000 + 64'(n0);
      cyc();
      if (s0_if.tvalid && s0_if.tready) begin
        push_exp(1'b0, s0_d);
        n0++;
      end
    end
    chk("full all beats issued", 64'(n0), 64'd6);
    drain();

    // Head-of-line: head tag is 0 with m0 stalled; m1's beat must wait.
    ret_limit = ret_done;
    send1(1'b0, 64'h7000_0000_0000_0000);
    send1(1'b1, 64'h7100_0000_0000_0000);
    m0_r = 0; m1_r = 1; ret_limit = BIG;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk1("hol m0 tvalid", m0_if.tvalid, 1'b1);
      chk1("hol m1 tvalid", m1_if.tvalid, 1'b0);
      chk1("hol enc_s tready", enc_s_if.tready, 1'b0);
    end
    drain();

    // Orphan return with the FIFO empty.
    orphan_inj = 1;
    cyc();
    chk1("orphan m0 tvalid", m0_if.tvalid, 1'b0);
    chk1("orphan m1 tvalid", m1_if.tvalid, 1'b0);
    chk1("orphan enc_s tready", enc_s_if.tready, 1'b0);
    orphan_inj = 0;
    cyc();
    chk1("orphan flag set", err_orphan, 1'b1);
    cyc(); cyc(); cyc();
    chk1("orphan flag sticky", err_orphan, 1'b1);
    chk("orphan outstanding", 64'(outstanding), 64'd0);
    rst = 0;
    cyc();
    rst = 1;
    cyc();
    chk1("orphan cleared by reset", err_orphan, 1'b0);
    chk("post reset outstanding", 64'(outstanding), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
